register_read_port: RTL and testbench

//   Read side of the general-purpose register set. Takes an operand-fetch request with two

---
 rtl/register_read_port_pkg.sv | 24 ++
 rtl/register_read_port_if.sv | 29 ++
 rtl/register_read_port_reg_bypass_mux.sv | 42 ++++
 rtl/register_read_port.sv | 102 ++++++++++
 tb/tb_register_read_port.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/register_read_port_pkg.sv
// Shared constants and FSM state type for the register read port.
// Register indices follow the x86 operand encoding.
package register_read_port_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_SEL_W    = 3;

  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

endpackage

// File: rtl/register_read_port_if.sv
// Request and operand handshake bundle between control unit, read port and ALU.
interface register_read_port_if
  import register_read_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [SEL_W-1:0]  src_a_sel;
  logic [SEL_W-1:0]  src_b_sel;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              sel_err;

  modport master (
    output req_valid, src_a_sel, src_b_sel, op_ready,
    input  req_ready, op_valid, op_a, op_b, sel_err
  );

  modport slave (
    input  req_valid, src_a_sel, src_b_sel, op_ready,
    output req_ready, op_valid, op_a, op_b, sel_err
  );

endinterface

// File: rtl/register_read_port_reg_bypass_mux.sv
// Combinational operand select: register lookup, same-cycle write forwarding,
// and range check. Out-of-range selects yield zero and raise err.
module reg_bypass_mux
  import register_read_port_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = DEF_SEL_W
) (
  input  logic [NUM_REGS*DATA_W-1:0] reg_file,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       wr_valid,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          value,
  output logic                       err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              in_range;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
    assign regs[gi] = reg_file[gi*DATA_W +: DATA_W];
  end

  assign in_range = (int'(sel) < NUM_REGS);

  always_comb begin
    value = '0;
    err   = !in_range;
    if (in_range) begin
      if (wr_valid && (wr_sel == sel)) begin
        value = wr_data;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (sel == SEL_W'(i)) value = regs[i];
        end
      end
    end
  end

endmodule

// File: rtl/register_read_port.sv
// Operand fetch port: latches two selects, snapshots the (forwarded) register
// values, and holds the pair on a valid/ready output until consumed.
module register_read_port
  import register_read_port_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = DEF_SEL_W
) (
  input  logic                       clock,
  input  logic                       reset,
  register_read_port_if.slave        bus,
  input  logic [NUM_REGS*DATA_W-1:0] reg_file,
  input  logic                       wr_valid,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data
);

  state_e            state_q,   state_d;
  logic [SEL_W-1:0]  sel_a_q,   sel_a_d;
  logic [SEL_W-1:0]  sel_b_q,   sel_b_d;
  logic [DATA_W-1:0] op_a_q,    op_a_d;
  logic [DATA_W-1:0] op_b_q,    op_b_d;
  logic              sel_err_q, sel_err_d;

  logic [SEL_W-1:0]  mux_sel [2];
  logic [DATA_W-1:0] mux_val [2];
  logic              mux_err [2];

  assign mux_sel[0] = sel_a_q;
  assign mux_sel[1] = sel_b_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    reg_bypass_mux #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
    ) u_mux (
      .reg_file (reg_file),
      .sel      (mux_sel[gi]),
      .wr_valid (wr_valid),
      .wr_sel   (wr_sel),
      .wr_data  (wr_data),
      .value    (mux_val[gi]),
      .err      (mux_err[gi])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Operands load only in CAPTURE, so writes seen in PRESENT never disturb the snapshot.
  always_comb begin
    state_d   = state_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sel_err_d = sel_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          sel_a_d = bus.src_a_sel;
          sel_b_d = bus.src_b_sel;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        op_a_d    = mux_val[0];
        op_b_d    = mux_val[1];
        sel_err_d = mux_err[0] | mux_err[1];
        state_d   = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.op_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.op_valid  = (state_q == ST_PRESENT);
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_register_read_port.sv
// Randomized and directed checks of register_read_port against a behavioural
// register-file model, with an 8-register and a 4-register instance in parallel.
module tb_register_read_port;
  import register_read_port_pkg::*;

  localparam int DW = 32;
  localparam int SW = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [8*DW-1:0] reg_file8 = '0;
  logic [4*DW-1:0] reg_file4;
  logic            wr_valid = 1'b0;
  logic [SW-1:0]   wr_sel   = '0;
  logic [DW-1:0]   wr_data  = '0;

  logic [DW-1:0] mem [8];
  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  register_read_port_if #(.DATA_W(DW), .SEL_W(SW)) bus8 ();
  register_read_port_if #(.DATA_W(DW), .SEL_W(SW)) bus4 ();

  assign reg_file4      = reg_file8[4*DW-1:0];
  assign bus4.req_valid = bus8.req_valid;
  assign bus4.src_a_sel = bus8.src_a_sel;
  assign bus4.src_b_sel = bus8.src_b_sel;
  assign bus4.op_ready  = bus8.op_ready;

  register_read_port #(.DATA_W(DW), .NUM_REGS(8), .SEL_W(SW)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8), .reg_file(reg_file8),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data)
  );

  register_read_port #(.DATA_W(DW), .NUM_REGS(4), .SEL_W(SW)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4), .reg_file(reg_file4),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  task automatic pack_mem();
    for (int i = 0; i < 8; i++) reg_file8[i*DW +: DW] = mem[i];
  endtask

  // Value the ALU should see for one source of an n-register port.
  function automatic logic [DW-1:0] exp_op(input int n, input int sel, input bit wr,
                                           input int wsel, input logic [DW-1:0] wdata);
    if (sel >= n) return '0;
    if (wr && wsel == sel) return wdata;
    return mem[sel];
  endfunction

  task automatic check_outputs(input string tag, input logic [DW-1:0] ea8, input logic [DW-1:0] eb8,
                               input logic [DW-1:0] ea4, input logic [DW-1:0] eb4, input bit ee4);
    check_eq({tag, "_valid8"}, bus8.op_valid, 1);
    check_eq({tag, "_a8"},     bus8.op_a, ea8);
    check_eq({tag, "_b8"},     bus8.op_b, eb8);
    check_eq({tag, "_err8"},   bus8.sel_err, 0);
    check_eq({tag, "_valid4"}, bus4.op_valid, 1);
    check_eq({tag, "_a4"},     bus4.op_a, ea4);
    check_eq({tag, "_b4"},     bus4.op_b, eb4);
    check_eq({tag, "_err4"},   bus4.sel_err, ee4);
  endtask

  task automatic run_txn(input int a, input int b, input bit wr, input int wsel,
                         input logic [DW-1:0] wdata, input int hold,
                         input logic [DW-1:0] hold_data, input bit rst_mid);
    logic [DW-1:0] ea8, eb8, ea4, eb4;
    bit ee4;
    n_txn++;
    @(negedge clock);
    check_eq("idle_ready8", bus8.req_ready, 1);
    check_eq("idle_ready4", bus4.req_ready, 1);
    check_eq("idle_valid8", bus8.op_valid, 0);
    bus8.req_valid = 1'b1;
    bus8.src_a_sel = SW'(a);
    bus8.src_b_sel = SW'(b);
    @(negedge clock);
    bus8.req_valid = 1'b0;
    check_eq("cap_ready8", bus8.req_ready, 0);
    check_eq("cap_valid8", bus8.op_valid, 0);
    wr_valid = wr;
    wr_sel   = SW'(wsel);
    wr_data  = wdata;
    ea8 = exp_op(8, a, wr, wsel, wdata);
    eb8 = exp_op(8, b, wr, wsel, wdata);
    ea4 = exp_op(4, a, wr, wsel, wdata);
    eb4 = exp_op(4, b, wr, wsel, wdata);
    ee4 = (a >= 4) || (b >= 4);
    @(negedge clock);
    wr_valid = 1'b0;
    if (wr) mem[wsel] = wdata;
    pack_mem();
    check_outputs("present", ea8, eb8, ea4, eb4, ee4);
    check_eq("present_ready8", bus8.req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      mem[b] = hold_data;
      pack_mem();
      wr_valid = 1'b1;
      wr_sel   = SW'(b);
      wr_data  = hold_data;
      @(negedge clock);
      check_outputs("hold", ea8, eb8, ea4, eb4, ee4);
      check_eq("hold_ready8", bus8.req_ready, 0);
      check_eq("hold_ready4", bus4.req_ready, 0);
    end
    wr_valid = 1'b0;
    if (rst_mid) begin
      reset = 1'b0;
      #1;
      check_eq("rst_valid8", bus8.op_valid, 0);
      check_eq("rst_a8", bus8.op_a, 0);
      check_eq("rst_b8", bus8.op_b, 0);
      check_eq("rst_valid4", bus4.op_valid, 0);
      check_eq("rst_err4", bus4.sel_err, 0);
      @(negedge clock);
      reset = 1'b1;
    end else begin
      bus8.op_ready = 1'b1;
      @(negedge clock);
      bus8.op_ready = 1'b0;
      check_eq("done_valid8", bus8.op_valid, 0);
      check_eq("done_ready8", bus8.req_ready, 1);
      check_eq("done_valid4", bus4.op_valid, 0);
    end
    $display("txn %0d a=%0d b=%0d wr=%0b wsel=%0d hold=%0d rst=%0b exp8=%h/%h exp4=%h/%h err4=%0b",
             n_txn, a, b, wr, wsel, hold, rst_mid, ea8, eb8, ea4, eb4, ee4);
  endtask

  // Back-to-back requests with op_ready high: one pair every third cycle.
  task automatic run_stream(input int count);
    logic [DW-1:0] e8, e4;
    int s;
    bus8.op_ready = 1'b1;
    for (int t = 0; t < count; t++) begin
      n_txn++;
      @(negedge clock);
      check_eq("strm_idle_ready8", bus8.req_ready, 1);
      check_eq("strm_idle_valid8", bus8.op_valid, 0);
      s = int'($urandom_range(0, 7));
      bus8.req_valid = 1'b1;
      bus8.src_a_sel = SW'(s);
      bus8.src_b_sel = SW'(s);
      @(negedge clock);
      check_eq("strm_cap_ready8", bus8.req_ready, 0);
      check_eq("strm_cap_valid8", bus8.op_valid, 0);
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      pack_mem();
      e8 = exp_op(8, s, 0, 0, '0);
      e4 = exp_op(4, s, 0, 0, '0);
      @(negedge clock);
      check_outputs("strm", e8, e8, e4, e4, s >= 4);
      check_eq("strm_a_eq_b", bus8.op_a, bus8.op_b);
      $display("txn %0d stream sel=%0d exp8=%h exp4=%h", n_txn, s, e8, e4);
    end
    bus8.req_valid = 1'b0;
    @(negedge clock);
    bus8.op_ready = 1'b0;
    check_eq("strm_end_ready8", bus8.req_ready, 1);
  endtask

  initial begin
    bus8.req_valid = 1'b0;
    bus8.src_a_sel = '0;
    bus8.src_b_sel = '0;
    bus8.op_ready  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + DW'(i);
    pack_mem();

    repeat (2) @(negedge clock);
    check_eq("reset_valid8", bus8.op_valid, 0);
    check_eq("reset_a8", bus8.op_a, 0);
    check_eq("reset_b8", bus8.op_b, 0);
    check_eq("reset_err4", bus4.sel_err, 0);
    reset = 1'b1;

    mem[REG_EAX] = 32'h11;
    mem[REG_EBX] = 32'h888;
    pack_mem();
    run_txn(REG_EAX, REG_EBX, 0, 0, '0, 0, '0, 0);
    run_txn(REG_EAX, REG_EBX, 1, REG_EBX, 32'hDEAD, 0, '0, 0);
    mem[REG_EBX] = 32'h888;
    pack_mem();
    run_txn(REG_EAX, REG_EBX, 0, 0, '0, 5, 32'hBEEF, 0);
    run_txn(REG_EAX, 5, 0, 0, '0, 0, '0, 0);
    run_txn(REG_ECX, REG_EBX, 0, 0, '0, 0, '0, 0);
    run_txn(REG_EDX, REG_ESI, 1, REG_EDX, 32'hCAFE, 1, 32'h1234, 1);
    run_txn(REG_EAX, REG_EAX, 1, REG_EAX, 32'h5A5A, 0, '0, 0);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      pack_mem();
      run_txn(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)), $urandom,
              ($urandom_range(0, 7) == 0));
    end

    run_stream(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
